// File: rtl/bp_me_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_me_pkg
// Purpose  : Shared types and sizing helpers for the io command arbiter.
// Revision : 1.0
// ============================================================================
package bp_me_pkg;

    localparam int cce_mem_msg_width_lp = 64;

    typedef enum logic [1:0] {
        e_arb_run   = 2'd0,
        e_arb_drain = 2'd1,
        e_arb_idle  = 2'd2
    } bp_io_arb_state_e;

    // Index width that stays at least one bit even for a single entry
    function automatic int bsg_safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    function automatic int bsg_width(input int x);
        return $clog2(x + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_io_cmd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bp_io_cmd_arbiter_if
// Purpose  : Requester-side and shared io-side buses of the command arbiter.
// Revision : 1.0
// ============================================================================
interface bp_io_cmd_arbiter_if
    import bp_me_pkg::*;
#(
    parameter int num_req_p   = 2,
    parameter int msg_width_p = cce_mem_msg_width_lp
);
    logic [num_req_p*msg_width_p-1:0] req_cmd_i;
    logic [num_req_p-1:0]             req_cmd_v_i;
    logic [num_req_p-1:0]             req_cmd_yumi_o;
    logic [num_req_p*msg_width_p-1:0] req_resp_o;
    logic [num_req_p-1:0]             req_resp_v_o;
    logic [num_req_p-1:0]             req_resp_ready_i;
    logic [msg_width_p-1:0]           io_cmd_o;
    logic                             io_cmd_v_o;
    logic                             io_cmd_yumi_i;
    logic [msg_width_p-1:0]           io_resp_i;
    logic                             io_resp_v_i;
    logic                             io_resp_ready_o;
    logic                             drain_i;
    logic                             idle_o;

    modport master (
        output req_cmd_i, req_cmd_v_i, req_resp_ready_i,
               io_cmd_yumi_i, io_resp_i, io_resp_v_i, drain_i,
        input  req_cmd_yumi_o, req_resp_o, req_resp_v_o,
               io_cmd_o, io_cmd_v_o, io_resp_ready_o, idle_o
    );

    modport slave (
        input  req_cmd_i, req_cmd_v_i, req_resp_ready_i,
               io_cmd_yumi_i, io_resp_i, io_resp_v_i, drain_i,
        output req_cmd_yumi_o, req_resp_o, req_resp_v_o,
               io_cmd_o, io_cmd_v_o, io_resp_ready_o, idle_o
    );
endinterface
`default_nettype wire

// File: rtl/bsg_fifo_1r1w_small.sv
`default_nettype none
// ============================================================================
// Module   : bsg_fifo_1r1w_small
// Purpose  : Small circular FIFO, one write and one read port, valid/yumi out.
// Revision : 1.0
// ============================================================================
module bsg_fifo_1r1w_small #(
    parameter int width_p = 1,
    parameter int els_p   = 2
) (
    input  wire logic               clk_i,
    input  wire logic               reset_i,
    input  wire logic               v_i,
    input  wire logic [width_p-1:0] data_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [width_p-1:0]      data_o,
    input  wire logic               yumi_i
);
    localparam int c_ptr_w = $clog2(els_p);

    // Pointers carry one extra wrap bit to tell full from empty
    logic [c_ptr_w:0]     r_wptr;
    logic [c_ptr_w:0]     r_rptr;
    logic [width_p-1:0]   r_mem [els_p];
    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_ptr_w] != r_rptr[c_ptr_w]) &&
                     (r_wptr[c_ptr_w-1:0] == r_rptr[c_ptr_w-1:0]);
    assign w_push  = v_i & ~w_full;
    assign w_pop   = yumi_i & ~w_empty;

    assign ready_o = ~w_full;
    assign v_o     = ~w_empty;
    assign data_o  = r_mem[r_rptr[c_ptr_w-1:0]];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr[c_ptr_w-1:0]] <= data_i;
    end
endmodule
`default_nettype wire

// File: rtl/bp_io_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bp_io_cmd_arbiter
// Purpose  : Round-robin merge of requester commands onto one credited io
//            channel, with in-order response routing back by requester ID.
// Revision : 1.0
// ============================================================================
module bp_io_cmd_arbiter
    import bp_me_pkg::*;
#(
    parameter int num_req_p     = 2,
    parameter int max_credits_p = 16,
    parameter int msg_width_p   = cce_mem_msg_width_lp
) (
    input  wire logic            clk_i,
    input  wire logic            reset_i,
    bp_io_cmd_arbiter_if.slave   io
);
    localparam int c_id_w  = bsg_safe_clog2(num_req_p);
    localparam int c_cnt_w = bsg_width(max_credits_p);
    localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(max_credits_p);

    typedef logic [c_id_w-1:0] id_t;

    bp_io_arb_state_e      r_state;
    bp_io_arb_state_e      w_state_nxt;
    logic [c_cnt_w-1:0]    r_count;
    logic [c_cnt_w-1:0]    w_count_nxt;
    id_t                   r_rr_ptr;
    logic                  r_lock_v;
    id_t                   r_lock_id;
    logic                  error_r;

    logic [msg_width_p-1:0] w_cmd_arr [num_req_p];
    id_t                   w_rr_sel;
    id_t                   w_sel;
    logic                  w_cmd_v;
    logic                  w_issue;
    logic                  w_retire;
    logic                  w_resp_ready;
    logic                  w_fifo_ready;
    logic                  w_fifo_v;
    id_t                   w_head;

    function automatic id_t f_wrap(input id_t base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= num_req_p) s = s - num_req_p;
        return id_t'(s);
    endfunction

    for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
        assign w_cmd_arr[g] = io.req_cmd_i[g*msg_width_p +: msg_width_p];
    end

    // Scan from the far end so the requester closest to the pointer wins
    always_comb begin
        w_rr_sel = r_rr_ptr;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            if (io.req_cmd_v_i[f_wrap(r_rr_ptr, i)]) w_rr_sel = f_wrap(r_rr_ptr, i);
        end
    end

    // An offered but unaccepted command keeps its requester until yumi
    assign w_sel    = (r_lock_v && io.req_cmd_v_i[r_lock_id]) ? r_lock_id : w_rr_sel;
    assign w_cmd_v  = ~reset_i && (r_state == e_arb_run) && (|io.req_cmd_v_i) &&
                      (r_count < c_max_cnt) && w_fifo_ready;
    assign w_issue  = w_cmd_v & io.io_cmd_yumi_i;

    assign io.io_cmd_v_o = w_cmd_v;
    assign io.io_cmd_o   = w_cmd_arr[w_sel];

    always_comb begin
        io.req_cmd_yumi_o = '0;
        io.req_resp_v_o   = '0;
        for (int i = 0; i < num_req_p; i++) begin
            io.req_cmd_yumi_o[i] = w_issue && (w_sel == id_t'(i));
            io.req_resp_v_o[i]   = w_fifo_v && io.io_resp_v_i && (w_head == id_t'(i));
        end
    end

    assign w_resp_ready       = w_fifo_v & io.req_resp_ready_i[w_head];
    assign w_retire           = io.io_resp_v_i & w_resp_ready;
    assign io.io_resp_ready_o = w_resp_ready;
    assign io.req_resp_o      = {num_req_p{io.io_resp_i}};
    assign io.idle_o          = (r_state == e_arb_idle);

    bsg_fifo_1r1w_small #(
        .width_p (c_id_w),
        .els_p   (max_credits_p)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (w_issue),
        .data_i  (w_sel),
        .ready_o (w_fifo_ready),
        .v_o     (w_fifo_v),
        .data_o  (w_head),
        .yumi_i  (w_retire)
    );

    always_comb begin
        w_count_nxt = r_count;
        if (w_issue && !w_retire)      w_count_nxt = r_count + 1'b1;
        else if (!w_issue && w_retire) w_count_nxt = r_count - 1'b1;
    end

    // Idle is declared as soon as the last outstanding response retires
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            e_arb_run:   if (io.drain_i) w_state_nxt = e_arb_drain;
            e_arb_drain: begin
                if (!io.drain_i)               w_state_nxt = e_arb_run;
                else if (w_count_nxt == '0)    w_state_nxt = e_arb_idle;
            end
            e_arb_idle:  if (!io.drain_i) w_state_nxt = e_arb_run;
            default:     w_state_nxt = e_arb_run;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= e_arb_run;
            r_count   <= '0;
            r_rr_ptr  <= '0;
            r_lock_v  <= 1'b0;
            r_lock_id <= '0;
            error_r   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_lock_v  <= w_cmd_v & ~io.io_cmd_yumi_i;
            r_lock_id <= w_sel;
            if (w_issue) r_rr_ptr <= f_wrap(w_sel, 1);
            if (io.io_resp_v_i && !w_fifo_v) error_r <= 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_bp_io_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_io_cmd_arbiter
// Purpose  : Directed scoreboard bench for bp_io_cmd_arbiter (2 requesters).
// Revision : 1.0
// ============================================================================
module tb_bp_io_cmd_arbiter;
    import bp_me_pkg::*;

    localparam int c_num_req = 2;
    localparam int c_credits = 16;
    localparam int c_msg_w   = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bp_io_cmd_arbiter_if #(.num_req_p(c_num_req), .msg_width_p(c_msg_w)) bus ();

    bp_io_cmd_arbiter #(
        .num_req_p     (c_num_req),
        .max_credits_p (c_credits),
        .msg_width_p   (c_msg_w)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .io      (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    logic [c_msg_w-1:0] cmd_q [$];
    int id_q  [$];
    int rsp_q [$];
    int seq   [c_num_req];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] payload(input int k, input int s);
        return {16'hC0DE, k[15:0], s[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmds();
        bus.req_cmd_i = {payload(1, seq[1]), payload(0, seq[0])};
    endtask

    // Expect requester id to be granted this cycle (io_cmd_yumi_i already 1)
    task automatic issue(input string tag, input int id);
        int exp_id;
        logic [63:0] exp_cmd;
        drive_cmds();
        cmd_q.push_back(payload(id, seq[id]));
        id_q.push_back(id);
        #1;
        exp_id  = id_q.pop_front();
        exp_cmd = cmd_q.pop_front();
        check({tag, "_v"},    bus.io_cmd_v_o, 1);
        check({tag, "_cmd"},  bus.io_cmd_o, exp_cmd);
        check({tag, "_yumi"}, bus.req_cmd_yumi_o, (exp_id == 0) ? 2'b01 : 2'b10);
        rsp_q.push_back(exp_id);
        seq[exp_id]++;
        tick();
    endtask

    // One response, all requesters ready; must land on the scoreboard head
    task automatic respond(input string tag);
        logic [63:0] data;
        logic [63:0] slice;
        int exp_id;
        data = {$urandom, $urandom};
        bus.io_resp_i   = data;
        bus.io_resp_v_i = 1'b1;
        #1;
        exp_id = rsp_q.pop_front();
        slice  = (exp_id == 0) ? bus.req_resp_o[63:0] : bus.req_resp_o[127:64];
        check({tag, "_rv"},   bus.req_resp_v_o, (exp_id == 0) ? 2'b01 : 2'b10);
        check({tag, "_rdy"},  bus.io_resp_ready_o, 1);
        check({tag, "_data"}, slice, data);
        tick();
        bus.io_resp_v_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        seq = '{0, 0};
        bus.req_cmd_i        = '0;
        bus.req_cmd_v_i      = 2'b11;
        bus.req_resp_ready_i = 2'b11;
        bus.io_cmd_yumi_i    = 1'b1;
        bus.io_resp_i        = '0;
        bus.io_resp_v_i      = 1'b1;
        bus.drain_i          = 1'b0;
        #2;
        check("rst_cmd_v",   bus.io_cmd_v_o, 0);
        check("rst_yumi",    bus.req_cmd_yumi_o, 0);
        check("rst_resp_v",  bus.req_resp_v_o, 0);
        check("rst_resp_rdy", bus.io_resp_ready_o, 0);
        check("rst_idle",    bus.idle_o, 0);
        check("rst_err",     dut.error_r, 0);
        check("rst_count",   dut.r_count, 0);
        bus.req_cmd_v_i   = 2'b00;
        bus.io_cmd_yumi_i = 1'b0;
        bus.io_resp_v_i   = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Both requesters valid: grants alternate starting at 0
        bus.req_cmd_v_i   = 2'b11;
        bus.io_cmd_yumi_i = 1'b1;
        for (int i = 0; i < 4; i++) issue("rr_alt", i % 2);
        bus.req_cmd_v_i   = 2'b00;
        bus.io_cmd_yumi_i = 1'b0;
        for (int i = 0; i < 4; i++) respond("rr_resp");

        // Credit limit: 16 issue, 17th blocked until one retire, then next cycle
        bus.req_cmd_v_i   = 2'b01;
        bus.io_cmd_yumi_i = 1'b1;
        for (int i = 0; i < c_credits; i++) issue("fill", 0);
        drive_cmds();
        #1;
        check("full_v",     bus.io_cmd_v_o, 0);
        check("full_yumi",  bus.req_cmd_yumi_o, 0);
        check("full_count", dut.r_count, c_credits);
        bus.io_resp_i   = 64'h1234_5678_9ABC_DEF0;
        bus.io_resp_v_i = 1'b1;
        #1;
        check("retire_cycle_v", bus.io_cmd_v_o, 0);
        check("retire_rdy",     bus.io_resp_ready_o, 1);
        tick();
        void'(rsp_q.pop_front());
        bus.io_resp_v_i = 1'b0;
        issue("reissue", 0);
        bus.req_cmd_v_i   = 2'b00;
        bus.io_cmd_yumi_i = 1'b0;
        for (int i = 0; i < c_credits; i++) respond("fill_resp");
        check("fill_empty", dut.r_count, 0);

        // Order r1,r0,r1 with a stall on requester 1
        bus.io_cmd_yumi_i = 1'b1;
        bus.req_cmd_v_i = 2'b10; issue("ord", 1);
        bus.req_cmd_v_i = 2'b01; issue("ord", 0);
        bus.req_cmd_v_i = 2'b10; issue("ord", 1);
        bus.req_cmd_v_i   = 2'b00;
        bus.io_cmd_yumi_i = 1'b0;
        bus.req_resp_ready_i = 2'b01;
        bus.io_resp_v_i      = 1'b1;
        #1;
        check("stall_rv",  bus.req_resp_v_o, 2'b10);
        check("stall_rdy", bus.io_resp_ready_o, 0);
        tick();
        check("stall_hold_rv", bus.req_resp_v_o, 2'b10);
        check("stall_count",   dut.r_count, 3);
        bus.io_resp_v_i      = 1'b0;
        bus.req_resp_ready_i = 2'b11;
        for (int i = 0; i < 3; i++) respond("ord_resp");

        // Selection held on requester 0 while unaccepted, despite pointer on 1
        bus.io_cmd_yumi_i = 1'b1;
        bus.req_cmd_v_i   = 2'b01;
        issue("lock_pre", 0);
        bus.io_cmd_yumi_i = 1'b0;
        drive_cmds();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("lock_v",    bus.io_cmd_v_o, 1);
            check("lock_cmd",  bus.io_cmd_o, payload(0, seq[0]));
            check("lock_yumi", bus.req_cmd_yumi_o, 0);
            tick();
        end
        bus.req_cmd_v_i = 2'b11;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("lock_hold_cmd", bus.io_cmd_o, payload(0, seq[0]));
            tick();
        end
        bus.io_cmd_yumi_i = 1'b1;
        issue("lock_accept", 0);
        bus.req_cmd_v_i   = 2'b00;
        bus.io_cmd_yumi_i = 1'b0;
        for (int i = 0; i < 2; i++) respond("lock_resp");

        // Drain with 3 outstanding
        bus.req_cmd_v_i   = 2'b11;
        bus.io_cmd_yumi_i = 1'b1;
        issue("pre_drain", 1);
        issue("pre_drain", 0);
        issue("pre_drain", 1);
        bus.req_cmd_v_i = 2'b00;
        bus.drain_i     = 1'b1;
        tick();
        bus.req_cmd_v_i = 2'b11;
        drive_cmds();
        #1;
        check("drain_v",    bus.io_cmd_v_o, 0);
        check("drain_yumi", bus.req_cmd_yumi_o, 0);
        check("drain_idle", bus.idle_o, 0);
        respond("drain_resp");
        respond("drain_resp");
        check("drain_idle_pre", bus.idle_o, 0);
        respond("drain_resp");
        check("drain_idle_post", bus.idle_o, 1);
        check("idle_v", bus.io_cmd_v_o, 0);
        bus.io_cmd_yumi_i = 1'b0;
        bus.drain_i       = 1'b0;
        tick();
        check("run_idle",  bus.idle_o, 0);
        check("run_state", dut.r_state, e_arb_run);
        check("run_v",     bus.io_cmd_v_o, 1);
        bus.req_cmd_v_i = 2'b00;

        // Reset mid-stream with 5 outstanding, then a stray response
        bus.req_cmd_v_i   = 2'b01;
        bus.io_cmd_yumi_i = 1'b1;
        for (int i = 0; i < 5; i++) issue("pre_rst", 0);
        check("pre_rst_count", dut.r_count, 5);
        drive_cmds();
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_v",     bus.io_cmd_v_o, 0);
        check("mid_rst_yumi",  bus.req_cmd_yumi_o, 0);
        check("mid_rst_count", dut.r_count, 0);
        check("mid_rst_rdy",   bus.io_resp_ready_o, 0);
        check("mid_rst_idle",  bus.idle_o, 0);
        rsp_q.delete();
        bus.req_cmd_v_i   = 2'b00;
        bus.io_cmd_yumi_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        bus.io_resp_v_i = 1'b1;
        #1;
        check("stray_rv",      bus.req_resp_v_o, 0);
        check("stray_rdy",     bus.io_resp_ready_o, 0);
        check("stray_err_pre", dut.error_r, 0);
        tick();
        bus.io_resp_v_i = 1'b0;
        check("stray_err", dut.error_r, 1);
        check("stray_count", dut.r_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bp_io_cmd_arbiter.md
BP_IO_CMD_ARBITER -- requirements
Module: bp_io_cmd_arbiter

Interface
REQ-001 SHALL have parameter num_req_p, default 2, number of command requesters (2..8).
REQ-002 SHALL have parameter max_credits_p, default 16, maximum commands outstanding on io_cmd_o (power of two, 2..64).
REQ-003 SHALL have parameter msg_width_p, default cce_mem_msg_width_lp, width of one io command/response message.
REQ-004 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_cmd_i  input  num_req_p*msg_width_p  per-requester command, requester 0 in LSBs.
REQ-007 SHALL have port req_cmd_v_i  input  num_req_p  per-requester command valid.
REQ-008 SHALL have port req_cmd_yumi_o  output  num_req_p  per-requester command accepted, one-hot or zero.
REQ-009 SHALL have port req_resp_o  output  num_req_p*msg_width_p  per-requester response; every slice carries io_resp_i.
REQ-010 SHALL have port req_resp_v_o  output  num_req_p  per-requester response valid.
REQ-011 SHALL have port req_resp_ready_i  input  num_req_p  per-requester response ready.
REQ-012 SHALL have ports io_cmd_o/io_cmd_v_o (output msg_width_p/1) and io_cmd_yumi_i (input 1): shared command channel, valid->yumi.
REQ-013 SHALL have ports io_resp_i/io_resp_v_i (input msg_width_p/1) and io_resp_ready_o (output 1): shared response channel, ready->valid.
REQ-014 SHALL have port drain_i  input  1  stop granting new commands.
REQ-015 SHALL have port idle_o  output  1  drained and zero commands outstanding.

Function
REQ-016 SHALL select one requester per cycle by round-robin among req_cmd_v_i, starting after the last requester accepted.
REQ-017 SHALL drive io_cmd_v_o = 1 only in state RUN, with at least one requester valid and fewer than max_credits_p commands outstanding.
REQ-018 SHALL drive io_cmd_o combinationally from the selected requester; zero added latency.
REQ-019 SHALL assert req_cmd_yumi_o[k] in the same cycle as io_cmd_yumi_i for selected requester k only.
REQ-020 SHALL hold the selection stable while io_cmd_v_o = 1 and io_cmd_yumi_i = 0; no re-arbitration while a command is offered.
REQ-021 SHALL advance the round-robin pointer only on io_cmd_yumi_i.
REQ-022 SHALL push the granted requester ID into an in-order tag FIFO of depth max_credits_p on each io_cmd_yumi_i.
REQ-023 SHALL route io_resp_i to the requester at the tag FIFO head: req_resp_v_o[head] = io_resp_v_i; all other bits 0.
REQ-024 SHALL drive io_resp_ready_o = req_resp_ready_i[head] when the FIFO is non-empty, else 0.
REQ-025 SHALL pop the tag FIFO and decrement the outstanding count on io_resp_v_i & io_resp_ready_o.
REQ-026 SHALL, on a same-cycle issue and retire, leave the outstanding count unchanged; at count = max_credits_p, a retire re-enables issue only from the next cycle.
REQ-027 SHALL ignore io_resp_v_i when the FIFO is empty (no routing, no pop) and hold sticky status error_r, readable via hierarchy.
REQ-028 SHALL implement states RUN, DRAIN and IDLE. RUN->DRAIN when drain_i = 1. DRAIN->IDLE when the outstanding count = 0. DRAIN or IDLE->RUN when drain_i = 0.
REQ-029 SHALL, in DRAIN and IDLE, grant nothing and continue to route responses.
REQ-030 SHALL drive idle_o = (state == IDLE).
REQ-031 SHALL size the outstanding counter to `BSG_WIDTH(max_credits_p); it never wraps.

Reset
REQ-032 SHALL, while reset_i = 1 (asynchronous), force state RUN, outstanding count 0, round-robin pointer to requester 0, FIFO empty, and error_r = 0.
REQ-033 SHALL hold io_cmd_v_o, req_cmd_yumi_o, req_resp_v_o, io_resp_ready_o and idle_o at 0 during reset.
REQ-034 SHALL discard in-flight commands on reset mid-operation; responses arriving after reset fall under REQ-027.

Structure
REQ-035 SHALL place the state enum (e_arb_run, e_arb_drain, e_arb_idle) in bp_me_pkg.
REQ-036 SHALL instantiate exactly one sub-module, bsg_fifo_1r1w_small, for the requester-ID tag FIFO (width `BSG_SAFE_CLOG2(num_req_p), els max_credits_p).

Verification
REQ-037 SHALL cover: both requesters valid continuously, io_cmd_yumi_i = 1 -> grants alternate 0,1,0,1.
REQ-038 SHALL cover: 16 issues with no responses (max_credits_p = 16) -> io_cmd_v_o = 0 on the 17th; one response -> the 17th issues on the next cycle.
REQ-039 SHALL cover: issue order r1,r0,r1 -> responses are routed r1,r0,r1; a response stalled by req_resp_ready_i[1] = 0 is not popped.
REQ-040 SHALL cover: drain_i = 1 with 3 outstanding -> no grants, idle_o = 1 one cycle after the third response; drain_i = 0 -> RUN.
REQ-041 SHALL cover: reset_i asserted mid-stream with 5 outstanding -> outputs 0 at once, count 0; a later stray response sets error_r.
REQ-042 SHALL cover: requester 0 valid while io_cmd_yumi_i is held 0 for 4 cycles, then requester 1 raises valid -> selection stays on requester 0 until accepted.
